// File: rtl/mem_pkg.sv
// mem_pkg: funct3 codes and FSM state encoding shared by the data memory controller.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store lane replication, load lane select/extend and misalign detect.
module mem_lane_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic [1:0]  sz;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        sz = funct3[1:0];
        b = 8'(rword >> {addr, 3'b000});
        h = 16'(rword >> {addr[1], 4'b0000});
        be = sz == 2'd0 ? 4'b0001 << addr : sz == 2'd1 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
        // replicating the data lets the byte enables pick the lane without a shifter
        wword = sz == 2'd0 ? {4{wdata[7:0]}} : sz == 2'd1 ? {2{wdata[15:0]}} : wdata;
        rdata = sz == 2'd0 ? {{24{b[7] & ~funct3[2]}}, b}
              : sz == 2'd1 ? {{16{h[15] & ~funct3[2]}}, h} : rword;
        misalign = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr != 2'd0);
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RV32 data memory with valid/ready request/response handshake,
// configurable wait states, byte-lane stores, extended loads and error detection.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_t            state, state_n;
    logic [3:0]        cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic              idle, a_we, legal, in_range, misalign, err, do_access;
    logic [2:0]        a_f3;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata, rword, wword, ext;
    logic [3:0]        be;
    logic [IW-1:0]     widx;
    assign idle      = state == ST_IDLE;
    assign req_ready = idle;
    assign busy      = !idle;
    assign rsp_valid = state == ST_RESP;
    // in IDLE the live request is used so a zero-wait access happens on the accept edge
    assign a_we    = idle ? req_we : we_q;
    assign a_f3    = idle ? req_funct3 : f3_q;
    assign a_addr  = idle ? req_addr : addr_q;
    assign a_wdata = idle ? req_wdata : wdata_q;
    assign widx    = a_addr[2 +: IW];
    assign rword   = mem[widx];
    assign in_range = (a_addr >> 2) < ADDR_W'(DEPTH_WORDS);
    assign legal = a_we ? (a_f3 == F3_B || a_f3 == F3_H || a_f3 == F3_W)
                        : (a_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign err = !legal || misalign || !in_range;
    mem_lane_align u_align (
        .funct3  (a_f3),
        .addr    (a_addr[1:0]),
        .wdata   (a_wdata),
        .rword   (rword),
        .be      (be),
        .wword   (wword),
        .rdata   (ext),
        .misalign(misalign)
    );
    always_comb begin
        state_n = state;
        do_access = 1'b0;
        case (state)
            ST_IDLE: if (req_valid) begin
                state_n = (err || WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                do_access = !err && WAIT_STATES == 0;
            end
            ST_WAIT: if (cnt == 4'd0) begin
                state_n = ST_RESP;
                do_access = 1'b1;
            end
            ST_RESP: if (rsp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
    // the array is deliberately not reset; holding reset simply blocks any write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= 4'd0;
            we_q <= 1'b0;
            f3_q <= 3'd0;
            addr_q <= '0;
            wdata_q <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_n;
            if (idle && req_valid) begin
                we_q <= req_we;
                f3_q <= req_funct3;
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                cnt <= 4'(WAIT_STATES - 1);
                rsp_err <= err;
            end else if (state == ST_WAIT) cnt <= cnt - 4'd1;
            if (do_access) begin
                rsp_rdata <= a_we ? 32'd0 : ext;
                if (a_we) for (int i = 0; i < 4; i++) if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
            if (rsp_valid && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with a 2-wait-state and a 0-wait-state instance.
module tb_data_mem_ctrl;
    import mem_pkg::*;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    logic        rv_a = 0, rr_a, we_a = 0, vv_a, rsr_a = 1, er_a, bz_a;
    logic [2:0]  f3_a = 0;
    logic [31:0] ad_a = 0, wd_a = 0, rd_a;
    logic        rv_z = 0, rr_z, we_z = 0, vv_z, rsr_z = 1, er_z, bz_z;
    logic [2:0]  f3_z = 0;
    logic [31:0] ad_z = 0, wd_z = 0, rd_z;
    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(2), .ADDR_W(32)) u_a (
        .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rr_a), .req_we(we_a),
        .req_funct3(f3_a), .req_addr(ad_a), .req_wdata(wd_a), .rsp_valid(vv_a),
        .rsp_ready(rsr_a), .rsp_rdata(rd_a), .rsp_err(er_a), .busy(bz_a)
    );
    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0), .ADDR_W(32)) u_z (
        .clk(clk), .reset(reset), .req_valid(rv_z), .req_ready(rr_z), .req_we(we_z),
        .req_funct3(f3_z), .req_addr(ad_z), .req_wdata(wd_z), .rsp_valid(vv_z),
        .rsp_ready(rsr_z), .rsp_rdata(rd_z), .rsp_err(er_z), .busy(bz_z)
    );
    typedef struct {logic [31:0] rdata; logic err; int acc; int lat;} exp_t;
    typedef struct {logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic err;} vec_t;
    exp_t qa[$], qz[$];
    int cyc = 0, passed = 0, total = 0;
    bit pend_a = 0, pend_z = 0;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic fail(input string name);
        total++;
        $display("FAIL %s: got event expected none", name);
    endtask
    task automatic req(input bit z, input vec_t v, output int acc);
        int n = 0;
        while (!(z ? rr_z : rr_a) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail("req_ready timeout");
        acc = cyc + 1;
        if (z) begin
            rv_z = 1; we_z = v.we; f3_z = v.f3; ad_z = v.addr; wd_z = v.wdata;
            qz.push_back('{v.rdata, v.err, acc, 0});
        end else begin
            rv_a = 1; we_a = v.we; f3_a = v.f3; ad_a = v.addr; wd_a = v.wdata;
            qa.push_back('{v.rdata, v.err, acc, v.err ? 0 : 2});
        end
        @(posedge clk); #1;
        if (z) begin
            rv_z = 0; ad_z = $urandom; wd_z = $urandom; f3_z = 3'($urandom);
        end else begin
            rv_a = 0; ad_a = $urandom; wd_a = $urandom; f3_a = 3'($urandom);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (reset) pend_a = 0;
        else begin
            if (vv_a && !pend_a) begin
                if (qa.size() == 0) fail("unexpected rsp a");
                else begin
                    e = qa.pop_front();
                    chk("rdata a", rd_a, e.rdata);
                    chk("err a", 32'(er_a), 32'(e.err));
                    chk("latency a", 32'(cyc - e.acc), 32'(e.lat));
                end
                pend_a = 1;
            end
            if (vv_a && rsr_a) pend_a = 0;
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (reset) pend_z = 0;
        else begin
            if (vv_z && !pend_z) begin
                if (qz.size() == 0) fail("unexpected rsp z");
                else begin
                    e = qz.pop_front();
                    chk("rdata z", rd_z, e.rdata);
                    chk("err z", 32'(er_z), 32'(e.err));
                    chk("latency z", 32'(cyc - e.acc), 32'(e.lat));
                end
                pend_z = 1;
            end
            if (vv_z && rsr_z) pend_z = 0;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        vec_t tbl[23];
        vec_t v;
        int acc, prev, n;
        logic [31:0] d;
        tbl = '{
            '{1'b1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, F3_B,  32'h12,  32'h12345680, 32'h0,        1'b0},
            '{1'b0, F3_B,  32'h12,  32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, F3_BU, 32'h12,  32'h0,        32'h00000080, 1'b0},
            '{1'b0, F3_H,  32'h12,  32'h0,        32'hFFFFDE80, 1'b0},
            '{1'b0, F3_HU, 32'h12,  32'h0,        32'h0000DE80, 1'b0},
            '{1'b0, F3_W,  32'h10,  32'h0,        32'hDE80BEEF, 1'b0},
            '{1'b0, F3_W,  32'h13,  32'h0,        32'h0,        1'b1},
            '{1'b1, F3_H,  32'h11,  32'h5555,     32'h0,        1'b1},
            '{1'b0, F3_W,  32'h10,  32'h0,        32'hDE80BEEF, 1'b0},
            '{1'b0, F3_W,  32'h100, 32'h0,        32'h0,        1'b1},
            '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1},
            '{1'b1, F3_BU, 32'h10,  32'h77,       32'h0,        1'b1},
            '{1'b1, F3_W,  32'h14,  32'hAABBCCDD, 32'h0,        1'b0},
            '{1'b1, F3_H,  32'h16,  32'hFFFF1234, 32'h0,        1'b0},
            '{1'b0, F3_W,  32'h14,  32'h0,        32'h1234CCDD, 1'b0},
            '{1'b0, F3_H,  32'h14,  32'h0,        32'hFFFFCCDD, 1'b0},
            '{1'b0, F3_B,  32'h15,  32'h0,        32'hFFFFFFCC, 1'b0},
            '{1'b0, F3_BU, 32'h17,  32'h0,        32'h00000012, 1'b0},
            '{1'b1, F3_W,  32'hFC,  32'h0BADF00D, 32'h0,        1'b0},
            '{1'b0, F3_W,  32'hFC,  32'h0,        32'h0BADF00D, 1'b0},
            '{1'b1, F3_W,  32'h20,  32'h0,        32'h0,        1'b0}
        };
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(rr_a), 32'd1);
        chk("reset rsp_valid", 32'(vv_a), 32'd0);
        chk("reset rsp_rdata", rd_a, 32'd0);
        chk("reset rsp_err", 32'(er_a), 32'd0);
        chk("reset busy", 32'(bz_a), 32'd0);
        reset = 0;
        for (int i = 0; i < 23; i++) req(0, tbl[i], acc);
        // backpressure: response held, request pulse ignored
        n = 0;
        while (!rr_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rsr_a = 0;
        req(0, '{1'b0, F3_W, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0}, acc);
        n = 0;
        while (!vv_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold rsp_valid", 32'(vv_a), 32'd1);
            chk("hold rsp_rdata", rd_a, 32'hDE80BEEF);
            chk("hold req_ready", 32'(rr_a), 32'd0);
            if (i == 1) begin
                rv_a = 1; we_a = 1; f3_a = F3_W; ad_a = 32'h10; wd_a = 32'h11111111;
            end
            if (i == 2) rv_a = 0;
        end
        rsr_a = 1;
        @(posedge clk); #1;
        chk("release req_ready", 32'(rr_a), 32'd1);
        chk("release rsp_valid", 32'(vv_a), 32'd0);
        chk("release rsp_rdata", rd_a, 32'd0);
        req(0, '{1'b0, F3_W, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0}, acc);
        // reset while a store waits
        n = 0;
        while (!rr_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rv_a = 1; we_a = 1; f3_a = F3_W; ad_a = 32'h20; wd_a = 32'h12345678;
        @(posedge clk); #1;
        rv_a = 0;
        chk("wait busy", 32'(bz_a), 32'd1);
        reset = 1;
        #1;
        chk("mid-wait reset busy", 32'(bz_a), 32'd0);
        chk("mid-wait reset req_ready", 32'(rr_a), 32'd1);
        @(posedge clk); #1;
        reset = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid-wait reset rsp_valid", 32'(vv_a), 32'd0);
        req(0, '{1'b0, F3_W, 32'h20, 32'h0, 32'h0, 1'b0}, acc);
        // zero wait states, back to back
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            req(1, '{1'b1, F3_W, 32'(32'h40 + 4 * i), d, 32'h0, 1'b0}, acc);
            if (i > 0) chk("b2b spacing sw", 32'(acc - prev), 32'd2);
            prev = acc;
            req(1, '{1'b0, F3_W, 32'(32'h40 + 4 * i), 32'h0, d, 1'b0}, acc);
            chk("b2b spacing lw", 32'(acc - prev), 32'd2);
            prev = acc;
        end
        req(1, '{1'b0, F3_H, 32'h41, 32'h0, 32'h0, 1'b1}, acc);
        n = 0;
        while ((qa.size() != 0 || qz.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail("drain timeout");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
